// File: rtl/rst_seq.sv
// Reset sequencer: resynchronizes PLL lock, waits for a stable-lock hold period,
// then releases the per-domain resets lowest index first, spaced by GAP cycles.
module rst_seq #(
   parameter int STAGES    = 3,
   parameter int HOLD      = 200,
   parameter int GAP       = 16,
   parameter int LOCK_SYNC = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              lock_i,
   output logic [STAGES-1:0] rst_o,
   output logic              done_o
);

   localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int IW   = (STAGES > 1) ? $clog2(STAGES) : 1;

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   // Index of the last bit already released when the final REL step fires
   localparam logic [IW-1:0] IDX_PEN   = IW'((STAGES >= 2) ? (STAGES - 2) : 0);

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_HOLD = 2'd1,
      S_REL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_idx;
   logic [STAGES-1:0]     r_rst;
   logic                  r_done;
   logic [LOCK_SYNC-1:0]  r_lock_sync;
   logic                  w_lock_s;

   // Lock resynchronizer chain, cleared while the upstream reset is asserted
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lock_sync <= {LOCK_SYNC{1'b0}};
      end else begin
         r_lock_sync[0] <= lock_i;
         for (int i = 1; i < LOCK_SYNC; i++) begin
            r_lock_sync[i] <= r_lock_sync[i-1];
         end
      end
   end

   assign w_lock_s = r_lock_sync[LOCK_SYNC-1];

   // Sequencing FSM; rst_o stays a thermometer code because bits only ever shift out from bit 0
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_WAIT;
         r_cnt   <= {CW{1'b0}};
         r_idx   <= {IW{1'b0}};
         r_rst   <= {STAGES{1'b1}};
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_WAIT: begin
               r_rst  <= {STAGES{1'b1}};
               r_done <= 1'b0;
               r_cnt  <= {CW{1'b0}};
               r_idx  <= {IW{1'b0}};
               if (w_lock_s) begin
                  r_state <= S_HOLD;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_HOLD: begin
               if (!w_lock_s) begin
                  r_state <= S_WAIT;
                  r_cnt   <= {CW{1'b0}};
               end else if (r_cnt == HOLD_LAST) begin
                  r_cnt <= {CW{1'b0}};
                  r_idx <= {IW{1'b0}};
                  r_rst <= r_rst << 1'b1;
                  if (STAGES == 1) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_REL;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_REL: begin
               // Lock loss outranks a terminal count in the same cycle
               if (!w_lock_s) begin
                  r_state <= S_WAIT;
                  r_cnt   <= {CW{1'b0}};
                  r_idx   <= {IW{1'b0}};
                  r_rst   <= {STAGES{1'b1}};
                  r_done  <= 1'b0;
               end else if (r_cnt == GAP_LAST) begin
                  r_cnt <= {CW{1'b0}};
                  r_idx <= r_idx + IDX_ONE;
                  r_rst <= r_rst << 1'b1;
                  if (r_idx == IDX_PEN) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_REL;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_DONE: begin
               if (!w_lock_s) begin
                  r_state <= S_WAIT;
                  r_cnt   <= {CW{1'b0}};
                  r_idx   <= {IW{1'b0}};
                  r_rst   <= {STAGES{1'b1}};
                  r_done  <= 1'b0;
               end else begin
                  r_rst  <= {STAGES{1'b0}};
                  r_done <= 1'b1;
               end
            end
            default: begin
               r_state <= S_WAIT;
               r_cnt   <= {CW{1'b0}};
               r_idx   <= {IW{1'b0}};
               r_rst   <= {STAGES{1'b1}};
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign rst_o  = r_rst;
   assign done_o = r_done;

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: scoreboarded timing scenarios on a 3-stage
// instance plus a 1-stage instance, ending with a random lock stream.
module tb_rst_seq;

   localparam int HOLD3 = 4;
   localparam int GAP3  = 2;

   typedef struct packed {
      logic [2:0] r;
      logic       d;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       lock_i = 1'b1;
   logic [2:0] rst3;
   logic       done3;
   logic [0:0] rst1;
   logic       done1;

   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];

   rst_seq #(.STAGES(3), .HOLD(HOLD3), .GAP(GAP3), .LOCK_SYNC(2)) dut3 (
      .clk_i(clk), .rst_i(rst_i), .lock_i(lock_i), .rst_o(rst3), .done_o(done3)
   );

   rst_seq #(.STAGES(1), .HOLD(1), .GAP(2), .LOCK_SYNC(2)) dut1 (
      .clk_i(clk), .rst_i(rst_i), .lock_i(lock_i), .rst_o(rst1), .done_o(done1)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected 3-stage outputs t cycles after HOLD entry (t<0: not yet entered)
   function automatic exp_t exp3(int t);
      exp_t e;
      for (int k = 0; k < 3; k++) e.r[k] = (t < HOLD3 + k * GAP3);
      e.d = (t >= HOLD3 + 2 * GAP3);
      return e;
   endfunction

   // Leaves rst_i low just after an edge, so the next edge is cycle 0
   task automatic do_reset();
      rst_i  = 1'b1;
      lock_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i  = 1'b1;
      lock_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (rst3 !== 3'b111) begin
            failures++;
            $display("FAIL reset_rst c=%0d got %b expected 111", c, rst3);
         end
         checks++;
         if (done3 !== 1'b0) begin
            failures++;
            $display("FAIL reset_done c=%0d got %b expected 0", c, done3);
         end
         checks++;
         if (dut3.r_lock_sync !== 2'b00) begin
            failures++;
            $display("FAIL reset_sync c=%0d got %b expected 00", c, dut3.r_lock_sync);
         end
      end
   endtask

   task automatic test_nominal();
      exp_t e;
      do_reset();
      for (int c = 0; c <= 14; c++) begin
         sb_q.push_back(exp3(c - 2));
         tick();
         e = sb_q.pop_front();
         checks++;
         if (rst3 !== e.r || done3 !== e.d) begin
            failures++;
            $display("FAIL nominal c=%0d got rst=%b done=%b expected rst=%b done=%b",
                     c, rst3, done3, e.r, e.d);
         end
      end
   endtask

   task automatic test_glitch_hold();
      exp_t e;
      do_reset();
      for (int c = 0; c <= 20; c++) begin
         lock_i = (c == 3) ? 1'b0 : 1'b1;
         sb_q.push_back(exp3(c - 6));
         tick();
         e = sb_q.pop_front();
         checks++;
         if (rst3 !== e.r || done3 !== e.d) begin
            failures++;
            $display("FAIL glitch_hold c=%0d got rst=%b done=%b expected rst=%b done=%b",
                     c, rst3, done3, e.r, e.d);
         end
      end
   endtask

   task automatic test_lock_loss_done();
      exp_t e;
      do_reset();
      for (int c = 0; c <= 40; c++) begin
         lock_i = (c >= 21 && c <= 24) ? 1'b0 : 1'b1;
         sb_q.push_back((c <= 22) ? exp3(c - 2) : exp3(c - 27));
         tick();
         e = sb_q.pop_front();
         checks++;
         if (rst3 !== e.r || done3 !== e.d) begin
            failures++;
            $display("FAIL lock_loss_done c=%0d got rst=%b done=%b expected rst=%b done=%b",
                     c, rst3, done3, e.r, e.d);
         end
      end
   endtask

   task automatic test_rst_mid_rel();
      exp_t e;
      do_reset();
      for (int c = 0; c <= 24; c++) begin
         rst_i = (c == 7) ? 1'b1 : 1'b0;
         sb_q.push_back((c <= 6) ? exp3(c - 2) : exp3(c - 10));
         tick();
         e = sb_q.pop_front();
         checks++;
         if (rst3 !== e.r || done3 !== e.d) begin
            failures++;
            $display("FAIL rst_mid_rel c=%0d got rst=%b done=%b expected rst=%b done=%b",
                     c, rst3, done3, e.r, e.d);
         end
      end
      rst_i = 1'b0;
   endtask

   task automatic test_single_stage();
      exp_t e;
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         e.r = {2'b00, ((c - 2) < 1)};
         e.d = ((c - 2) >= 1);
         sb_q.push_back(e);
         tick();
         e = sb_q.pop_front();
         checks++;
         if (rst1 !== e.r[0] || done1 !== e.d) begin
            failures++;
            $display("FAIL single_stage c=%0d got rst=%b done=%b expected rst=%b done=%b",
                     c, rst1, done1, e.r[0], e.d);
         end
      end
   endtask

   task automatic test_random_lock();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         lock_i = ($urandom_range(0, 7) != 0);
         tick();
         checks++;
         if (!(rst3 == 3'b111 || rst3 == 3'b110 || rst3 == 3'b100 || rst3 == 3'b000)
             || done3 !== (rst3 == 3'b000)) begin
            failures++;
            $display("FAIL thermo3 c=%0d got rst=%b done=%b expected thermometer with done iff 000",
                     c, rst3, done3);
         end
         checks++;
         if (done1 !== ~rst1[0]) begin
            failures++;
            $display("FAIL thermo1 c=%0d got rst=%b done=%b expected done == ~rst",
                     c, rst1, done1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_glitch_hold();
      test_lock_loss_done();
      test_rst_mid_rel();
      test_single_stage();
      test_random_lock();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
